// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed 7-segment driver for packed BCD digits, with a per-frame snapshot and registered pin outputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module bcd_7seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int COMMON_ANODE = 1
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic             INV      = (COMMON_ANODE != 0);
  localparam logic [6:0]       SEG_OFF  = {7{INV}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{INV}};

  logic [DIV_W-1:0]    div_cnt_reg, div_cnt_next;
  logic [IDX_W-1:0]    digit_idx_reg, digit_idx_next;
  logic [4*DIGITS-1:0] snap_bcd_reg, snap_bcd_next;
  logic [DIGITS-1:0]   snap_dp_reg, snap_dp_next;
  logic [6:0]          seg_reg, seg_next;
  logic                dp_reg, dp_next;
  logic [DIGITS-1:0]   an_reg, an_next;
  logic                frame_tick_reg, frame_tick_next;

  logic                wrap;
  logic                frame_load;
  logic [3:0]          snap_digit [DIGITS];
  logic [DIGITS-1:0]   digit_sel;
  logic [DIGITS-1:0]   blank_vec;
  logic [3:0]          cur_nibble;
  logic                cur_dp;
  logic                cur_blank;
  logic [6:0]          seg_decoded;
  logic [6:0]          seg_active;

  assign wrap       = (div_cnt_reg == DIV_LAST);
  assign frame_load = wrap && (digit_idx_reg == IDX_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign snap_digit[gi] = snap_bcd_reg[4*gi +: 4];
      assign digit_sel[gi]  = (digit_idx_reg == IDX_W'(gi));
`ifdef LEADING_ZERO_BLANK_EN
      // A digit is leading when it and every digit above it are zero.
      if (gi == 0) begin : g_keep
        assign blank_vec[gi] = 1'b0;
      end else begin : g_lzb
        assign blank_vec[gi] = (snap_bcd_reg[4*DIGITS-1:4*gi] == '0);
      end
`else
      assign blank_vec[gi] = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    div_cnt_next   = wrap ? '0 : div_cnt_reg + DIV_W'(1);
    digit_idx_next = digit_idx_reg;
    if (wrap) begin
      digit_idx_next = (digit_idx_reg == IDX_LAST) ? '0 : digit_idx_reg + IDX_W'(1);
    end
    snap_bcd_next   = frame_load ? bcd_in : snap_bcd_reg;
    snap_dp_next    = frame_load ? dp_in  : snap_dp_reg;
    frame_tick_next = frame_load;
  end

  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_sel[k]) begin
        cur_nibble = snap_digit[k];
        cur_dp     = snap_dp_reg[k];
        cur_blank  = blank_vec[k];
      end
    end
  end

  always_comb begin
    seg_decoded = 7'b1000000;
    case (cur_nibble)
      4'd0: seg_decoded = 7'b0111111;
      4'd1: seg_decoded = 7'b0000110;
      4'd2: seg_decoded = 7'b1011011;
      4'd3: seg_decoded = 7'b1001111;
      4'd4: seg_decoded = 7'b1100110;
      4'd5: seg_decoded = 7'b1101101;
      4'd6: seg_decoded = 7'b1111101;
      4'd7: seg_decoded = 7'b0000111;
      4'd8: seg_decoded = 7'b1111111;
      4'd9: seg_decoded = 7'b1101111;
      default: seg_decoded = 7'b1000000;
    endcase
  end

  // Output polarity is applied last so the decode stays active-high.
  always_comb begin
    seg_active = cur_blank ? 7'h00 : seg_decoded;
    seg_next   = SEG_OFF ^ seg_active;
    dp_next    = INV ^ cur_dp;
    an_next    = AN_OFF ^ digit_sel;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      div_cnt_reg    <= '0;
      digit_idx_reg  <= '0;
      snap_bcd_reg   <= '0;
      snap_dp_reg    <= '0;
      seg_reg        <= SEG_OFF;
      dp_reg         <= INV;
      an_reg         <= AN_OFF;
      frame_tick_reg <= 1'b0;
    end else begin
      div_cnt_reg    <= div_cnt_next;
      digit_idx_reg  <= digit_idx_next;
      snap_bcd_reg   <= snap_bcd_next;
      snap_dp_reg    <= snap_dp_next;
      seg_reg        <= seg_next;
      dp_reg         <= dp_next;
      an_reg         <= an_next;
      frame_tick_reg <= frame_tick_next;
    end
  end

  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign an         = an_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Bench for bcd_7seg_scan_driver: 4-digit and 1-digit instances against a frame/timing reference model.
module tb_bcd_7seg_scan_driver;

  localparam int D = 4;
  localparam int R = 4;

  logic        clk;
  logic        clear_n;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;
  logic [6:0]  seg1;
  logic        dp1;
  logic [0:0]  an1;
  logic        ft1;

  bcd_7seg_scan_driver #(.DIGITS(D), .REFRESH_DIV(R), .COMMON_ANODE(1)) dut (
    .clk(clk), .clear_n(clear_n), .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  bcd_7seg_scan_driver #(.DIGITS(1), .REFRESH_DIV(2), .COMMON_ANODE(1)) dut1 (
    .clk(clk), .clear_n(clear_n), .bcd_in(bcd_in[3:0]), .dp_in(dp_in[0:0]),
    .seg(seg1), .dp(dp1), .an(an1), .frame_tick(ft1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dpv;
    logic [3:0][6:0] seg_exp;
    logic [3:0]      dp_exp;
  } vec_t;

  vec_t vecs [6];
  int   asserts = 0;
  int   fails   = 0;
  int   n       = 0;
  int   last_idx;
  bit   last_tick;
  logic [15:0] snap_bcd;
  logic [3:0]  snap_dp;
  logic [3:0]  snap1_bcd;
  logic        snap1_dp;

  function automatic logic [6:0] decode(logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Expected common-anode segment pins for digit k of a snapshot.
  function automatic logic [6:0] model_seg(logic [15:0] s, int k);
    logic [3:0] nib;
    nib = s[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && (s >> (4*k)) == 16'h0) return 7'h7F;
`endif
    return ~decode(nib);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
    end
  endtask

  // One clock: predict outputs after this edge, then compare on the falling edge.
  task automatic step();
    logic [3:0] one;
    logic [3:0] e_an;
    logic [6:0] e_seg, e1_seg;
    logic       e_dp, e1_dp, e_tick, e1_tick;
    one = 4'b0001;
    @(posedge clk);
    n++;
    last_idx = ((n - 1) / R) % D;
    e_an    = ~(one << last_idx);
    e_seg   = model_seg(snap_bcd, last_idx);
    e_dp    = ~snap_dp[last_idx];
    e_tick  = (n % (D * R) == 0);
    e1_seg  = ~decode(snap1_bcd);
    e1_dp   = ~snap1_dp;
    e1_tick = (n % 2 == 0);
    if (e_tick) begin
      snap_bcd = bcd_in;
      snap_dp  = dp_in;
    end
    if (e1_tick) begin
      snap1_bcd = bcd_in[3:0];
      snap1_dp  = dp_in[0];
    end
    last_tick = e_tick;
    @(negedge clk);
    check("scan4", {19'h0, an, seg, dp, frame_tick}, {19'h0, e_an, e_seg, e_dp, e_tick});
    check("scan1", {19'h0, 3'h0, an1, seg1, dp1, ft1}, {19'h0, 4'h0, e1_seg, e1_dp, e1_tick});
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 clear_n = 1'b0;
    #1;
    check("reset4", {19'h0, an, seg, dp, frame_tick}, {19'h0, 4'hF, 7'h7F, 1'b1, 1'b0});
    check("reset1", {19'h0, 3'h0, an1, seg1, dp1, ft1}, {19'h0, 4'h1, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    clear_n   = 1'b1;
    n         = 0;
    snap_bcd  = '0;
    snap_dp   = '0;
    snap1_bcd = '0;
    snap1_dp  = 1'b0;
    step();
    check("after_reset", {25'h0, an, seg}, {25'h0, 4'hE, 7'h40});
  endtask

  task automatic wait_model_tick();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!last_tick && k < 40);
    check("tick_found", {31'h0, last_tick}, 32'h1);
  endtask

  initial begin
    int cnt;
    logic [15:0] r;
    clear_n = 1'b1;
    bcd_in  = '0;
    dp_in   = '0;

    vecs[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
    vecs[1] = '{16'h9999, 4'b0000, {7'h10, 7'h10, 7'h10, 7'h10}, 4'hF};
    vecs[4] = '{16'h8F07, 4'b0101, {7'h00, 7'h3F, 7'h40, 7'h78}, 4'b1010};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[2] = '{16'h00A0, 4'b0010, {7'h7F, 7'h7F, 7'h3F, 7'h40}, 4'b1101};
    vecs[3] = '{16'h0050, 4'b0000, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
    vecs[5] = '{16'h0000, 4'b1000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111};
`else
    vecs[2] = '{16'h00A0, 4'b0010, {7'h40, 7'h40, 7'h3F, 7'h40}, 4'b1101};
    vecs[3] = '{16'h0050, 4'b0000, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF};
    vecs[5] = '{16'h0000, 4'b1000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0111};
`endif

    do_reset();

    for (int i = 0; i < 6; i++) begin
      bcd_in = vecs[i].bcd;
      dp_in  = vecs[i].dpv;
      wait_model_tick();
      for (int c = 0; c < D * R; c++) begin
        step();
        check("table_seg", {25'h0, seg}, {25'h0, vecs[i].seg_exp[last_idx]});
        check("table_dp", {31'h0, dp}, {31'h0, vecs[i].dp_exp[last_idx]});
      end
      $display("vector %0d: bcd_in=%h dp_in=%b done", i, vecs[i].bcd, vecs[i].dpv);
    end

    // Tearing: change input mid-frame, display must hold until the next snapshot.
    bcd_in = 16'h1234;
    dp_in  = 4'h0;
    wait_model_tick();
    for (int c = 0; c < 6; c++) step();
    bcd_in = 16'h9999;
    cnt = 0;
    do begin
      step();
      cnt++;
      if (!frame_tick) check("tear_hold", {31'h0, (seg != 7'h10)}, 32'h1);
    end while (!frame_tick && cnt < 40);
    step();
    check("tear_after", {25'h0, seg}, {25'h0, 7'h10});
    cnt = 1;
    do begin
      step();
      cnt++;
    end while (!frame_tick && cnt < 40);
    check("tick_period", cnt, 32'd16);
    $display("tear sequence done: tick period %0d", cnt);

    // Randomized traffic with a mid-frame reset.
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < 4; k++) begin
          r[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        end
        bcd_in = r;
        dp_in  = 4'($urandom_range(0, 15));
      end
      if (c == 157) do_reset();
      step();
    end
    $display("random phase done");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
